// File: rtl/storage_sequencer_pkg.sv
// Shared constants and state encoding for the per-event storage sequencer.
package storage_sequencer_pkg;

    localparam int DEF_SSIDBITS      = 12;
    localparam int DEF_MAXHITS       = 256;
    localparam int DEF_CLEAR_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        S_CLEAR      = 3'd0,
        S_WAIT_CLEAR = 3'd1,
        S_WRITE      = 3'd2,
        S_READ       = 3'd3,
        S_WAIT_READ  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/storage_sequencer_timeout.sv
// Loadable up-counter with a terminal-count flag; watchdog for the clear phase.
module seq_timeout_counter #(
    parameter int WIDTH    = 10,
    parameter int TERMINAL = 1023
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic enable,
    output logic terminal
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign terminal = (count_q == WIDTH'(TERMINAL));

endmodule

// File: rtl/storage_sequencer.sv
// Event sequencer for the SSID block-memory storage: clear, write hits, read,
// then start over. Acts as the storage's address source in the event flow.
module storage_sequencer
    import storage_sequencer_pkg::*;
#(
    parameter int SSIDBITS      = DEF_SSIDBITS,
    parameter int MAXHITS       = DEF_MAXHITS,
    parameter int CLEAR_TIMEOUT = DEF_CLEAR_TIMEOUT,
    parameter int HITCNTBITS    = $clog2(MAXHITS + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  hitValid,
    input  logic [SSIDBITS-1:0]   hitSSID,
    output logic                  hitReady,
    input  logic                  endEvent,
    input  logic                  storageReady,
    input  logic                  readReady,
    output logic                  clearMemory,
    output logic                  readMemory,
    output logic                  newAddress,
    output logic [SSIDBITS-1:0]   SSID,
    output logic [HITCNTBITS-1:0] hitCount,
    output logic                  overflow,
    output logic                  timeoutError,
    output logic                  eventDone,
    output logic                  busy
);

    localparam int TOBITS = $clog2(CLEAR_TIMEOUT + 1);
    localparam logic [HITCNTBITS-1:0] MAX_CNT = HITCNTBITS'(MAXHITS);

    seq_state_e            state_q, state_d;
    logic                  clear_memory_q, clear_memory_d;
    logic                  read_memory_q, read_memory_d;
    logic                  new_address_q, new_address_d;
    logic [SSIDBITS-1:0]   ssid_q, ssid_d;
    logic [HITCNTBITS-1:0] hit_count_q, hit_count_d;
    logic                  overflow_q, overflow_d;
    logic                  timeout_error_q, timeout_error_d;
    logic                  event_done_q, event_done_d;
    logic                  busy_q, busy_d;
    logic                  to_load, to_enable, to_terminal;

    seq_timeout_counter #(
        .WIDTH    (TOBITS),
        .TERMINAL (CLEAR_TIMEOUT - 1)
    ) u_timeout (
        .clock    (clock),
        .reset    (reset),
        .load     (to_load),
        .enable   (to_enable),
        .terminal (to_terminal)
    );

    assign hitReady = (state_q == S_WRITE) && storageReady && (hit_count_q < MAX_CNT);

    always_comb begin
        state_d         = state_q;
        clear_memory_d  = 1'b0;
        read_memory_d   = 1'b0;
        new_address_d   = 1'b0;
        ssid_d          = ssid_q;
        hit_count_d     = hit_count_q;
        overflow_d      = overflow_q;
        timeout_error_d = timeout_error_q;
        event_done_d    = 1'b0;
        to_load         = 1'b1;
        to_enable       = 1'b0;

        case (state_q)
            S_CLEAR: begin
                clear_memory_d = 1'b1;
                hit_count_d    = '0;
                overflow_d     = 1'b0;
                state_d        = S_WAIT_CLEAR;
            end
            S_WAIT_CLEAR: begin
                to_enable = 1'b1;
                to_load   = storageReady || to_terminal;
                if (storageReady) begin
                    state_d = S_WRITE;
                end else if (to_terminal) begin
                    timeout_error_d = 1'b1;
                    state_d         = S_CLEAR;
                end
            end
            S_WRITE: begin
                if (hitValid && hitReady) begin
                    new_address_d = 1'b1;
                    ssid_d        = hitSSID;
                    hit_count_d   = hit_count_q + HITCNTBITS'(1);
                end
                if (hitValid && (hit_count_q == MAX_CNT)) begin
                    overflow_d = 1'b1;
                end
                if (endEvent) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // A write accepted alongside endEvent is already on newAddress
                // this cycle, so a read registered now always lands after it.
                read_memory_d = 1'b1;
                state_d       = S_WAIT_READ;
            end
            S_WAIT_READ: begin
                if (readReady) begin
                    event_done_d = 1'b1;
                    state_d      = S_CLEAR;
                end
            end
            default: state_d = S_CLEAR;
        endcase

        busy_d = (state_d != S_WRITE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= S_CLEAR;
            clear_memory_q  <= 1'b0;
            read_memory_q   <= 1'b0;
            new_address_q   <= 1'b0;
            ssid_q          <= '0;
            hit_count_q     <= '0;
            overflow_q      <= 1'b0;
            timeout_error_q <= 1'b0;
            event_done_q    <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            clear_memory_q  <= clear_memory_d;
            read_memory_q   <= read_memory_d;
            new_address_q   <= new_address_d;
            ssid_q          <= ssid_d;
            hit_count_q     <= hit_count_d;
            overflow_q      <= overflow_d;
            timeout_error_q <= timeout_error_d;
            event_done_q    <= event_done_d;
            busy_q          <= busy_d;
        end
    end

    assign clearMemory  = clear_memory_q;
    assign readMemory   = read_memory_q;
    assign newAddress   = new_address_q;
    assign SSID         = ssid_q;
    assign hitCount     = hit_count_q;
    assign overflow     = overflow_q;
    assign timeoutError = timeout_error_q;
    assign eventDone    = event_done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_storage_sequencer.sv
// Scoreboard bench for storage_sequencer with a small MAXHITS / CLEAR_TIMEOUT.
module tb_storage_sequencer;

    localparam int SB = 12;
    localparam int MH = 4;
    localparam int CT = 8;
    localparam int HB = $clog2(MH + 1);

    logic          clock, reset, hitValid, hitReady, endEvent, storageReady, readReady;
    logic          clearMemory, readMemory, newAddress, overflow, timeoutError, eventDone, busy;
    logic [SB-1:0] hitSSID, SSID;
    logic [HB-1:0] hitCount;

    typedef struct {
        logic [SB-1:0] ssid;
        int            cyc;
    } wr_t;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  clear_cnt = 0, read_cnt = 0, done_cnt = 0;
    bit  excl_bad = 0;
    wr_t exp_q[$];
    wr_t obs_q[$];

    storage_sequencer #(
        .SSIDBITS      (SB),
        .MAXHITS       (MH),
        .CLEAR_TIMEOUT (CT),
        .HITCNTBITS    (HB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .hitValid     (hitValid),
        .hitSSID      (hitSSID),
        .hitReady     (hitReady),
        .endEvent     (endEvent),
        .storageReady (storageReady),
        .readReady    (readReady),
        .clearMemory  (clearMemory),
        .readMemory   (readMemory),
        .newAddress   (newAddress),
        .SSID         (SSID),
        .hitCount     (hitCount),
        .overflow     (overflow),
        .timeoutError (timeoutError),
        .eventDone    (eventDone),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: log writes and pulses mid-cycle.
    always @(negedge clock) begin
        if (newAddress === 1'b1) obs_q.push_back('{ssid: SSID, cyc: cyc});
        if (clearMemory === 1'b1) clear_cnt++;
        if (readMemory === 1'b1) read_cnt++;
        if (eventDone === 1'b1) done_cnt++;
        if (int'(clearMemory === 1'b1) + int'(readMemory === 1'b1) + int'(newAddress === 1'b1) > 1)
            excl_bad = 1'b1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_write();
        int n = 0;
        while (busy !== 1'b0 && n < 50) begin step(); n++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL wait_write busy=%b required 0", busy); end
    endtask

    task automatic wait_read(output int rc);
        int n = 0;
        while (readMemory !== 1'b1 && n < 20) begin step(); n++; end
        rc = cyc;
        checks++;
        if (readMemory !== 1'b1) begin errors++; $display("FAIL wait_read readMemory=%b required 1", readMemory); end
    endtask

    task automatic complete_read(input int delay);
        int n = 0;
        repeat (delay) step();
        readReady = 1'b1;
        step();
        readReady = 1'b0;
        while (eventDone !== 1'b1 && n < 10) begin step(); n++; end
        checks++;
        if (eventDone !== 1'b1) begin errors++; $display("FAIL event_done eventDone=%b required 1", eventDone); end
    endtask

    task automatic drain_scoreboard();
        wr_t e, o;
        @(negedge clock);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL write_missing got none required ssid=%h cyc=%0d", e.ssid, e.cyc);
            end else begin
                o = obs_q.pop_front();
                if (o.ssid !== e.ssid || o.cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL write got ssid=%h cyc=%0d required ssid=%h cyc=%0d", o.ssid, o.cyc, e.ssid, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL extra_write got %0d extra newAddress pulses required 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; hitValid = 1'b0; hitSSID = '0; endEvent = 1'b0;
        storageReady = 1'b0; readReady = 1'b0;
        repeat (3) step();
        checks++;
        if ({clearMemory, readMemory, newAddress, hitReady, overflow, timeoutError, eventDone, busy} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs got %b required 00000000",
                     {clearMemory, readMemory, newAddress, hitReady, overflow, timeoutError, eventDone, busy});
        end
        checks++;
        if (hitCount !== '0 || SSID !== '0) begin
            errors++; $display("FAIL reset_count hitCount=%0d SSID=%h required 0 0", hitCount, SSID);
        end
    endtask

    task automatic test_empty_event();
        int c0, r0, d0, rc;
        storageReady = 1'b1;
        c0 = clear_cnt; r0 = read_cnt; d0 = done_cnt;
        reset = 1'b0;
        step();
        checks++;
        if (clearMemory !== 1'b1) begin errors++; $display("FAIL first_clear clearMemory=%b required 1", clearMemory); end
        wait_write();
        endEvent = 1'b1;
        step();
        endEvent = 1'b0;
        wait_read(rc);
        complete_read(2);
        checks++;
        if (hitCount !== '0) begin errors++; $display("FAIL empty_count hitCount=%0d required 0", hitCount); end
        @(negedge clock);
        #1;
        checks++;
        if (clear_cnt - c0 != 1 || read_cnt - r0 != 1 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL empty_pulses clear=%0d read=%0d done=%0d required 1 1 1",
                     clear_cnt - c0, read_cnt - r0, done_cnt - d0);
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL empty_writes got %0d required 0", obs_q.size()); end
        obs_q.delete();
    endtask

    task automatic test_three_hits();
        logic [SB-1:0] ss [3];
        int rc;
        ss[0] = 12'h005; ss[1] = 12'h0A3; ss[2] = 12'hFFF;
        wait_write();
        for (int i = 0; i < 3; i++) begin
            hitValid = 1'b1;
            hitSSID  = ss[i];
            checks++;
            if (hitReady !== 1'b1) begin errors++; $display("FAIL three_ready[%0d] hitReady=%b required 1", i, hitReady); end
            exp_q.push_back('{ssid: ss[i], cyc: cyc + 1});
            step();
        end
        hitValid = 1'b0;
        checks++;
        if (hitCount !== HB'(3)) begin errors++; $display("FAIL three_count hitCount=%0d required 3", hitCount); end
        drain_scoreboard();
        endEvent = 1'b1;
        step();
        endEvent = 1'b0;
        wait_read(rc);
        complete_read(1);
        checks++;
        if (hitCount !== HB'(3)) begin errors++; $display("FAIL three_hold hitCount=%0d required 3", hitCount); end
    endtask

    task automatic test_overflow();
        int acc = 0;
        int rc;
        logic exp_rdy;
        wait_write();
        for (int i = 0; i < 6; i++) begin
            hitValid = 1'b1;
            hitSSID  = 12'h100 + SB'(i);
            exp_rdy  = (acc < MH);
            checks++;
            if (hitReady !== exp_rdy) begin
                errors++; $display("FAIL ovf_ready[%0d] hitReady=%b required %b", i, hitReady, exp_rdy);
            end
            if (exp_rdy) begin
                exp_q.push_back('{ssid: hitSSID, cyc: cyc + 1});
                acc++;
            end
            step();
        end
        hitValid = 1'b0;
        checks++;
        if (overflow !== 1'b1 || hitCount !== HB'(MH) || hitReady !== 1'b0) begin
            errors++;
            $display("FAIL ovf_state overflow=%b hitCount=%0d hitReady=%b required 1 %0d 0",
                     overflow, hitCount, hitReady, MH);
        end
        drain_scoreboard();
        endEvent = 1'b1;
        step();
        endEvent = 1'b0;
        wait_read(rc);
        complete_read(1);
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_hold overflow=%b required 1", overflow); end
    endtask

    task automatic test_hit_with_end();
        int exp_rc, rc;
        wait_write();
        checks++;
        if (overflow !== 1'b0 || hitCount !== '0) begin
            errors++; $display("FAIL ovf_cleared overflow=%b hitCount=%0d required 0 0", overflow, hitCount);
        end
        hitValid = 1'b1;
        hitSSID  = 12'h123;
        endEvent = 1'b1;
        checks++;
        if (hitReady !== 1'b1) begin errors++; $display("FAIL end_ready hitReady=%b required 1", hitReady); end
        exp_q.push_back('{ssid: 12'h123, cyc: cyc + 1});
        exp_rc = cyc + 2;
        step();
        hitValid = 1'b0;
        endEvent = 1'b0;
        wait_read(rc);
        checks++;
        if (rc != exp_rc) begin errors++; $display("FAIL end_read_cycle got %0d required %0d", rc, exp_rc); end
        checks++;
        if (hitCount !== HB'(1)) begin errors++; $display("FAIL end_count hitCount=%0d required 1", hitCount); end
        drain_scoreboard();
        complete_read(1);
    endtask

    task automatic test_timeout();
        storageReady = 1'b0;
        step();
        checks++;
        if (clearMemory !== 1'b1 || timeoutError !== 1'b0) begin
            errors++; $display("FAIL to_start clear=%b timeoutError=%b required 1 0", clearMemory, timeoutError);
        end
        repeat (CT - 1) step();
        checks++;
        if (timeoutError !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL to_early timeoutError=%b busy=%b required 0 1", timeoutError, busy);
        end
        step();
        checks++;
        if (timeoutError !== 1'b1 || clearMemory !== 1'b0) begin
            errors++; $display("FAIL to_flag timeoutError=%b clear=%b required 1 0", timeoutError, clearMemory);
        end
        step();
        checks++;
        if (clearMemory !== 1'b1) begin errors++; $display("FAIL to_reclear clearMemory=%b required 1", clearMemory); end
        storageReady = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || hitReady !== 1'b1 || timeoutError !== 1'b1) begin
            errors++;
            $display("FAIL to_write busy=%b hitReady=%b timeoutError=%b required 0 1 1", busy, hitReady, timeoutError);
        end
    endtask

    task automatic test_reset_mid_event();
        hitValid = 1'b1;
        hitSSID  = 12'h0AA;
        exp_q.push_back('{ssid: 12'h0AA, cyc: cyc + 1});
        step();
        hitSSID  = 12'h0BB;
        exp_q.push_back('{ssid: 12'h0BB, cyc: cyc + 1});
        step();
        hitValid = 1'b0;
        checks++;
        if (hitCount !== HB'(2)) begin errors++; $display("FAIL mid_count hitCount=%0d required 2", hitCount); end
        drain_scoreboard();
        reset    = 1'b1;
        hitValid = 1'b1;
        hitSSID  = 12'h0CC;
        step();
        checks++;
        if ({clearMemory, readMemory, newAddress, hitReady, overflow, timeoutError, eventDone, busy} !== 8'h00
            || hitCount !== '0) begin
            errors++;
            $display("FAIL mid_reset outputs=%b hitCount=%0d required 00000000 0",
                     {clearMemory, readMemory, newAddress, hitReady, overflow, timeoutError, eventDone, busy}, hitCount);
        end
        reset    = 1'b0;
        hitValid = 1'b0;
        step();
        checks++;
        if (clearMemory !== 1'b1) begin errors++; $display("FAIL mid_clear clearMemory=%b required 1", clearMemory); end
        @(negedge clock);
        #1;
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL mid_dropped got %0d writes required 0", obs_q.size()); end
        checks++;
        if (excl_bad) begin errors++; $display("FAIL exclusive got overlapping strobes required none"); end
    endtask

    initial begin
        test_reset();
        test_empty_event();
        test_three_hits();
        test_overflow();
        test_hit_with_end();
        test_timeout();
        test_reset_mid_event();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/storage_sequencer.md
Name: storage_sequencer

Overview:
- Per-event controller for the SSID block-memory storage. It sequences the storage through clear, write and read phases.
- Sits between the upstream hit stream (SSID + valid) and BlockMemoryStorage. It drives that block's clearMemory, readMemory, newAddress and SSID inputs, and watches storageReady and readReady.
- It replaces the free-running AddressCounter as the storage's address source in the event-based flow.

Parameters:
- SSIDBITS, 12, SSID width; the shared value in MyParameters.vh is authoritative.
- MAXHITS, 256, maximum hits written per event.
- CLEAR_TIMEOUT, 1024, cycles to wait for storageReady after a clear before flagging an error.
- HITCNTBITS, $clog2(MAXHITS+1), width of the hit counter.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- hitValid  in  1  upstream hit present.
- hitSSID  in  SSIDBITS  upstream hit SSID.
- hitReady  out  1  controller accepts a hit this cycle.
- endEvent  in  1  one-cycle end-of-event marker.
- storageReady  in  1  storage idle/ready, from BlockMemoryStorage.
- readReady  in  1  read phase complete, from BlockMemoryStorage.
- clearMemory  out  1  clear pulse to storage.
- readMemory  out  1  read pulse to storage.
- newAddress  out  1  write strobe to storage.
- SSID  out  SSIDBITS  SSID to storage, valid while newAddress=1.
- hitCount  out  HITCNTBITS  hits written in the current event.
- overflow  out  1  sticky for the event: a hit was refused at MAXHITS.
- timeoutError  out  1  sticky until reset: a clear timed out.
- eventDone  out  1  one-cycle pulse at read completion.
- busy  out  1  high in any state except WRITE.

Behaviour:
- Reset (synchronous, priority over everything):
  - state=CLEAR; all outputs 0; hitCount, overflow, timeoutError and the timeout counter cleared.
  - Any pending newAddress is dropped.
  - Reset asserted mid-event behaves identically.
- All outputs are registered.
- CLEAR:
  - clearMemory=1 for exactly one cycle; next state WAIT_CLEAR.
  - hitCount and overflow clear here.
- WAIT_CLEAR:
  - The timeout counter increments each cycle.
  - storageReady=1 → WRITE, counter zeroed.
  - Counter reaches CLEAR_TIMEOUT-1 without storageReady → timeoutError=1, back to CLEAR (retry indefinitely).
- WRITE:
  - hitReady = storageReady && hitCount<MAXHITS, computed combinationally from registered state.
  - Transfer when hitValid && hitReady. In the next cycle newAddress=1 for one cycle, SSID=the captured hitSSID, and hitCount increments.
  - Back-to-back transfers give back-to-back newAddress pulses.
  - hitValid=1 with hitCount==MAXHITS → overflow=1 and the hit is not written. The upstream is expected to drop it; hitReady stays low.
  - endEvent=1 → READ next cycle. A hit transferred in the same cycle is still written and counted.
  - endEvent while storageReady=0 still ends the event.
- READ:
  - readMemory=1 for exactly one cycle.
  - It is issued no earlier than the cycle after the last newAddress pulse. Delay one cycle if that pulse is still in flight.
  - Next state WAIT_READ.
- WAIT_READ:
  - readReady=1 → eventDone=1 for one cycle, then CLEAR.
  - hitCount and overflow hold their values through the eventDone cycle.
- Handshake rules:
  - endEvent outside WRITE is ignored.
  - hitReady=0 in every state except WRITE.
  - clearMemory, readMemory and newAddress are never high in the same cycle.
- hitCount saturates at MAXHITS; no wrap.
- Minimum event round-trip, zero hits and immediate ready responses: CLEAR, WAIT_CLEAR, WRITE, READ, WAIT_READ = 5 cycles.

Decomposition:
- Shared MyParameters.vh holds:
  - SSIDBITS;
  - MAXHITS;
  - CLEAR_TIMEOUT;
  - the state encoding localparams S_CLEAR, S_WAIT_CLEAR, S_WRITE, S_READ, S_WAIT_READ.
- One natural sub-module: seq_timeout_counter. It is a loadable up-counter with terminal-count flag, used for the WAIT_CLEAR watchdog.
- The FSM, hit capture register and hit counter remain in storage_sequencer.

Test Plan:
- Reset then storageReady held 1, no hits, endEvent at cycle 4, readReady returned 2 cycles after readMemory → one clearMemory pulse, one readMemory pulse, eventDone once, hitCount=0.
- Three consecutive hits SSID=0x005,0x0A3,0xFFF → three consecutive newAddress pulses each one cycle after transfer, with those SSIDs in order, hitCount=3.
- MAXHITS=4, six hits offered → four writes, hitReady low after the fourth, overflow=1; overflow cleared after the next CLEAR.
- Hit SSID=0x123 and endEvent in the same cycle → the hit is written, hitCount=1, and readMemory rises one cycle after that newAddress.
- storageReady held 0, CLEAR_TIMEOUT=8 → timeoutError=1 after 8 WAIT_CLEAR cycles, a new clearMemory pulse follows; raising storageReady then enters WRITE.
- Reset asserted while in WRITE with 2 hits written → next cycle all outputs 0, hitCount=0, clearMemory pulses on the cycle after reset deasserts.
